// File: rtl/config_store.sv
// config_store: configuration store for a small spiking-neuron core.
//
// Holds the neuron parameter set (threshold, leak, refractory period and the
// signed voltage limits) and an N_INPUT x N_OUTPUT synapse weight table. All
// three control strobes arrive as levels from the SPI front end and are turned
// into single-cycle events by rising-edge detection.
//
// Ports:
//   sclk, reset                    clock, asynchronous active-high reset
//   load_params                    strobe: commit the candidate parameter set
//   update_synapse                 strobe: write syn_weight at (syn_src, syn_dst)
//   net_reset                      strobe: zero the weight table (one entry/cycle)
//   param_threshold/leak/refr      unsigned candidate parameters
//   param_vmax/vmin                signed candidate voltage limits
//   syn_src, syn_dst, syn_weight   synapse write request
//   rd_src, rd_dst                 weight read address
//   rd_weight                      registered read data (0 for bad address)
//   threshold/leak/refr/vmax/vmin  committed neuron parameters
//   cfg_valid                      a parameter set has been committed
//   busy                           clear sweep in progress
//   err_range, err_param, err_drop sticky error flags
//   wr_count                       committed synapse writes, saturating at 255
module config_store #(
  parameter int WIDTH    = 16,
  parameter int N_INPUT  = 4,
  parameter int N_OUTPUT = 3
) (
  input  logic                        sclk,
  input  logic                        reset,
  input  logic                        load_params,
  input  logic                        update_synapse,
  input  logic                        net_reset,
  input  logic [WIDTH-1:0]            param_threshold,
  input  logic [WIDTH-1:0]            param_leak,
  input  logic [WIDTH-1:0]            param_refr,
  input  logic signed [WIDTH-1:0]     param_vmax,
  input  logic signed [WIDTH-1:0]     param_vmin,
  input  logic [$clog2(N_INPUT)-1:0]  syn_src,
  input  logic [$clog2(N_OUTPUT)-1:0] syn_dst,
  input  logic signed [WIDTH-1:0]     syn_weight,
  input  logic [$clog2(N_INPUT)-1:0]  rd_src,
  input  logic [$clog2(N_OUTPUT)-1:0] rd_dst,
  output logic signed [WIDTH-1:0]     rd_weight,
  output logic [WIDTH-1:0]            threshold,
  output logic [WIDTH-1:0]            leak,
  output logic [WIDTH-1:0]            refr,
  output logic signed [WIDTH-1:0]     vmax,
  output logic signed [WIDTH-1:0]     vmin,
  output logic                        cfg_valid,
  output logic                        busy,
  output logic                        err_range,
  output logic                        err_param,
  output logic                        err_drop,
  output logic [7:0]                  wr_count
);

  localparam int SW      = $clog2(N_INPUT);
  localparam int DW      = $clog2(N_OUTPUT);
  localparam int N_ENTRY = N_INPUT * N_OUTPUT;
  localparam int IW      = $clog2(N_ENTRY);

  // One extra bit so the entry counts themselves are representable.
  localparam logic [SW:0]   SRC_LIMIT = N_INPUT[SW:0];
  localparam logic [DW:0]   DST_LIMIT = N_OUTPUT[DW:0];
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_ENTRY - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    sweepIdx_q, sweepIdx_d;
  logic             loadPrev_q, updPrev_q, netPrev_q;
  logic [WIDTH-1:0] threshold_q, threshold_d;
  logic [WIDTH-1:0] leak_q, leak_d;
  logic [WIDTH-1:0] refr_q, refr_d;
  logic [WIDTH-1:0] vmax_q, vmax_d;
  logic [WIDTH-1:0] vmin_q, vmin_d;
  logic             cfgValid_q, cfgValid_d;
  logic             errRange_q, errRange_d;
  logic             errParam_q, errParam_d;
  logic             errDrop_q, errDrop_d;
  logic [7:0]       wrCount_q, wrCount_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic [WIDTH-1:0] mem_q [N_ENTRY];

  logic          loadEv, updEv, netEv;
  logic          synInRange, rdInRange, wrEn, loadOk;
  logic [IW-1:0] wrIdx, rdIdx;

  assign loadEv = load_params & ~loadPrev_q;
  assign updEv  = update_synapse & ~updPrev_q;
  assign netEv  = net_reset & ~netPrev_q;

  assign synInRange = ({1'b0, syn_src} < SRC_LIMIT) && ({1'b0, syn_dst} < DST_LIMIT);
  assign rdInRange  = ({1'b0, rd_src} < SRC_LIMIT) && ({1'b0, rd_dst} < DST_LIMIT);
  assign wrIdx      = IW'(syn_src) * IW'(N_OUTPUT) + IW'(syn_dst);
  assign rdIdx      = IW'(rd_src) * IW'(N_OUTPUT) + IW'(rd_dst);

  // A write only lands when idle and no clear starts on the same edge.
  assign wrEn   = updEv && (state_q == ST_IDLE) && !netEv && synInRange;
  assign loadOk = $signed(param_vmin) < $signed(param_vmax);

  // Next-state logic. Error sets are applied after the net_reset clear so a
  // fault detected on the clearing edge is still recorded.
  always_comb begin
    state_d     = state_q;
    sweepIdx_d  = sweepIdx_q;
    threshold_d = threshold_q;
    leak_d      = leak_q;
    refr_d      = refr_q;
    vmax_d      = vmax_q;
    vmin_d      = vmin_q;
    cfgValid_d  = cfgValid_q;
    errRange_d  = errRange_q;
    errParam_d  = errParam_q;
    errDrop_d   = errDrop_q;
    wrCount_d   = wrCount_q;
    rdData_d    = rdInRange ? mem_q[rdIdx] : '0;

    case (state_q)
      ST_IDLE: begin
        if (netEv) begin
          state_d    = ST_CLEAR;
          sweepIdx_d = '0;
        end
      end
      default: begin
        if (netEv) begin
          sweepIdx_d = '0;
        end else if (sweepIdx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          sweepIdx_d = '0;
        end else begin
          sweepIdx_d = sweepIdx_q + 1'b1;
        end
      end
    endcase

    if (netEv) begin
      errRange_d = 1'b0;
      errParam_d = 1'b0;
      errDrop_d  = 1'b0;
      wrCount_d  = '0;
    end

    if (updEv) begin
      if ((state_q == ST_CLEAR) || netEv) begin
        errDrop_d = 1'b1;
      end else if (!synInRange) begin
        errRange_d = 1'b1;
      end
    end

    if (wrEn && (wrCount_q != 8'hFF)) begin
      wrCount_d = wrCount_q + 8'd1;
    end

    if (loadEv) begin
      if (loadOk) begin
        threshold_d = param_threshold;
        leak_d      = param_leak;
        refr_d      = param_refr;
        vmax_d      = param_vmax;
        vmin_d      = param_vmin;
        cfgValid_d  = 1'b1;
      end else begin
        errParam_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sweepIdx_q  <= '0;
      loadPrev_q  <= 1'b0;
      updPrev_q   <= 1'b0;
      netPrev_q   <= 1'b0;
      threshold_q <= '0;
      leak_q      <= '0;
      refr_q      <= '0;
      vmax_q      <= '0;
      vmin_q      <= '0;
      cfgValid_q  <= 1'b0;
      errRange_q  <= 1'b0;
      errParam_q  <= 1'b0;
      errDrop_q   <= 1'b0;
      wrCount_q   <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweepIdx_q  <= sweepIdx_d;
      loadPrev_q  <= load_params;
      updPrev_q   <= update_synapse;
      netPrev_q   <= net_reset;
      threshold_q <= threshold_d;
      leak_q      <= leak_d;
      refr_q      <= refr_d;
      vmax_q      <= vmax_d;
      vmin_q      <= vmin_d;
      cfgValid_q  <= cfgValid_d;
      errRange_q  <= errRange_d;
      errParam_q  <= errParam_d;
      errDrop_q   <= errDrop_d;
      wrCount_q   <= wrCount_d;
      rdData_q    <= rdData_d;
    end
  end

  // Weight table. The sweep and host writes never coincide because writes are
  // only accepted in IDLE; reads sample the pre-edge value (read-before-write).
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[sweepIdx_q] <= '0;
    end else if (wrEn) begin
      mem_q[wrIdx] <= syn_weight;
    end
  end

  assign rd_weight = rdData_q;
  assign threshold = threshold_q;
  assign leak      = leak_q;
  assign refr      = refr_q;
  assign vmax      = vmax_q;
  assign vmin      = vmin_q;
  assign cfg_valid = cfgValid_q;
  assign busy      = (state_q == ST_CLEAR);
  assign err_range = errRange_q;
  assign err_param = errParam_q;
  assign err_drop  = errDrop_q;
  assign wr_count  = wrCount_q;

endmodule

// File: tb/tb_config_store.sv
// tb_config_store: directed testbench for config_store with the default
// parameters (WIDTH=16, N_INPUT=4, N_OUTPUT=3, 12 weight entries).
// Inputs are driven just after the falling edge; outputs are sampled on the
// falling edge, half a period after the rising edge that produced them.
module tb_config_store;

  logic        sclk;
  logic        reset;
  logic        load_params, update_synapse, net_reset;
  logic [15:0] param_threshold, param_leak, param_refr;
  logic [15:0] param_vmax, param_vmin;
  logic [1:0]  syn_src, syn_dst, rd_src, rd_dst;
  logic [15:0] syn_weight;
  logic [15:0] rd_weight, threshold, leak, refr, vmax, vmin;
  logic        cfg_valid, busy, err_range, err_param, err_drop;
  logic [7:0]  wr_count;

  int testCount = 0;
  int failCount = 0;
  int busyCount;
  logic [15:0] rdVal;

  config_store dut (
    .sclk(sclk), .reset(reset),
    .load_params(load_params), .update_synapse(update_synapse), .net_reset(net_reset),
    .param_threshold(param_threshold), .param_leak(param_leak), .param_refr(param_refr),
    .param_vmax(param_vmax), .param_vmin(param_vmin),
    .syn_src(syn_src), .syn_dst(syn_dst), .syn_weight(syn_weight),
    .rd_src(rd_src), .rd_dst(rd_dst), .rd_weight(rd_weight),
    .threshold(threshold), .leak(leak), .refr(refr), .vmax(vmax), .vmin(vmin),
    .cfg_valid(cfg_valid), .busy(busy),
    .err_range(err_range), .err_param(err_param), .err_drop(err_drop),
    .wr_count(wr_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // One update_synapse pulse (one cycle high, one cycle low).
  task automatic applyStimulus(input logic [1:0] s, input logic [1:0] d, input logic [15:0] w);
    syn_src = s; syn_dst = d; syn_weight = w;
    update_synapse = 1'b1;
    cycle(1);
    update_synapse = 1'b0;
    cycle(1);
  endtask

  task automatic readWeight(input logic [1:0] s, input logic [1:0] d, output logic [15:0] v);
    rd_src = s; rd_dst = d;
    cycle(1);
    v = rd_weight;
  endtask

  // Counts busy cycles over a fixed window that is well beyond one sweep.
  task automatic countBusy(input int window, output int cnt);
    cnt = 0;
    for (int i = 0; i < window; i++) begin
      cycle(1);
      if (busy) cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    load_params = 0; update_synapse = 0; net_reset = 0;
    param_threshold = 0; param_leak = 0; param_refr = 0; param_vmax = 0; param_vmin = 0;
    syn_src = 0; syn_dst = 0; syn_weight = 0; rd_src = 0; rd_dst = 0;

    #12;
    checkOutput("rst_threshold", threshold, 16'h0000);
    checkOutput("rst_cfg_valid", cfg_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_wr_count", wr_count, 8'd0);
    @(negedge sclk);
    reset = 1'b0;
    cycle(1);

    // Valid load held high for five cycles; a later change must not re-latch.
    param_threshold = 16'h0100; param_leak = 16'h0005; param_refr = 16'h0003;
    param_vmin = 16'hFF00; param_vmax = 16'h0200;
    load_params = 1'b1;
    cycle(1);
    param_threshold = 16'h0111;
    cycle(4);
    load_params = 1'b0;
    cycle(1);
    checkOutput("load_threshold", threshold, 16'h0100);
    checkOutput("load_leak", leak, 16'h0005);
    checkOutput("load_refr", refr, 16'h0003);
    checkOutput("load_vmin", vmin, 16'hFF00);
    checkOutput("load_vmax", vmax, 16'h0200);
    checkOutput("load_cfg_valid", cfg_valid, 1'b1);
    checkOutput("load_err_param", err_param, 1'b0);

    // vmin == vmax is rejected.
    param_threshold = 16'h0999; param_vmin = 16'h0010; param_vmax = 16'h0010;
    load_params = 1'b1;
    cycle(1);
    load_params = 1'b0;
    cycle(1);
    checkOutput("bad_threshold", threshold, 16'h0100);
    checkOutput("bad_vmin", vmin, 16'hFF00);
    checkOutput("bad_vmax", vmax, 16'h0200);
    checkOutput("bad_err_param", err_param, 1'b1);

    // Write (2,1) while reading it: old value first, new value next cycle.
    syn_src = 2'd2; syn_dst = 2'd1; syn_weight = 16'hFFF6;
    rd_src = 2'd2; rd_dst = 2'd1;
    update_synapse = 1'b1;
    cycle(1);
    checkOutput("rbw_old", rd_weight, 16'h0000);
    update_synapse = 1'b0;
    cycle(1);
    checkOutput("rd_2_1", rd_weight, 16'hFFF6);
    checkOutput("wr_count_1", wr_count, 8'd1);

    applyStimulus(2'd2, 2'd3, 16'h1234);
    checkOutput("range_err", err_range, 1'b1);
    checkOutput("range_wr_count", wr_count, 8'd1);
    readWeight(2'd2, 2'd3, rdVal);
    checkOutput("rd_oor", rdVal, 16'h0000);
    readWeight(2'd3, 2'd0, rdVal);
    checkOutput("rd_3_0_untouched", rdVal, 16'h0000);
    readWeight(2'd2, 2'd1, rdVal);
    checkOutput("rd_2_1_kept", rdVal, 16'hFFF6);
    applyStimulus(2'd0, 2'd0, 16'h0007);
    checkOutput("wr_count_2", wr_count, 8'd2);

    // Clear sweep with a dropped write in the middle.
    net_reset = 1'b1;
    busyCount = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1);
      if (busy) busyCount++;
      if (i == 2) begin
        syn_src = 2'd1; syn_dst = 2'd1; syn_weight = 16'h0055;
        update_synapse = 1'b1;
      end
      if (i == 3) update_synapse = 1'b0;
    end
    checkOutput("clear_busy_cycles", busyCount, 32'd12);
    checkOutput("clear_err_range", err_range, 1'b0);
    checkOutput("clear_err_param", err_param, 1'b0);
    checkOutput("clear_wr_count", wr_count, 8'd0);
    checkOutput("clear_err_drop", err_drop, 1'b1);
    checkOutput("clear_cfg_kept", cfg_valid, 1'b1);
    checkOutput("clear_threshold_kept", threshold, 16'h0100);
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 3; d++) begin
        readWeight(2'(s), 2'(d), rdVal);
        checkOutput($sformatf("clear_entry_%0d_%0d", s, d), rdVal, 16'h0000);
      end
    end

    // A plain clear drops err_drop back to zero.
    net_reset = 1'b0;
    cycle(1);
    net_reset = 1'b1;
    countBusy(20, busyCount);
    checkOutput("clear2_busy_cycles", busyCount, 32'd12);
    checkOutput("clear2_err_drop", err_drop, 1'b0);
    net_reset = 1'b0;
    cycle(1);

    // net_reset and update_synapse rising together: clear wins, write dropped.
    applyStimulus(2'd0, 2'd2, 16'h0033);
    checkOutput("pre_same_wr_count", wr_count, 8'd1);
    syn_src = 2'd0; syn_dst = 2'd1; syn_weight = 16'h0044;
    net_reset = 1'b1; update_synapse = 1'b1;
    cycle(1);
    update_synapse = 1'b0;
    checkOutput("same_busy", busy, 1'b1);
    checkOutput("same_err_drop", err_drop, 1'b1);
    checkOutput("same_wr_count", wr_count, 8'd0);
    countBusy(20, busyCount);
    checkOutput("same_busy_rest", busyCount, 32'd11);
    readWeight(2'd0, 2'd1, rdVal);
    checkOutput("same_entry_0_1", rdVal, 16'h0000);
    readWeight(2'd0, 2'd2, rdVal);
    checkOutput("same_entry_0_2", rdVal, 16'h0000);
    net_reset = 1'b0;
    cycle(1);

    // 256 valid writes saturate the counter at 255.
    for (int i = 0; i < 255; i++) applyStimulus(2'd3, 2'd2, 16'h0ABC);
    checkOutput("wr_count_255", wr_count, 8'd255);
    applyStimulus(2'd3, 2'd2, 16'h0ABC);
    checkOutput("wr_count_sat", wr_count, 8'd255);
    readWeight(2'd3, 2'd2, rdVal);
    checkOutput("rd_3_2", rdVal, 16'h0ABC);

    // Reset at sweep cycle 5 aborts everything immediately.
    net_reset = 1'b1;
    cycle(5);
    checkOutput("sweep_busy_c5", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_threshold", threshold, 16'h0000);
    checkOutput("abort_cfg_valid", cfg_valid, 1'b0);
    checkOutput("abort_wr_count", wr_count, 8'd0);
    net_reset = 1'b0;
    @(negedge sclk);
    reset = 1'b0;
    cycle(1);
    checkOutput("post_busy", busy, 1'b0);
    checkOutput("post_vmax", vmax, 16'h0000);
    checkOutput("post_vmin", vmin, 16'h0000);
    checkOutput("post_err_drop", err_drop, 1'b0);
    readWeight(2'd3, 2'd2, rdVal);
    checkOutput("post_entry_3_2", rdVal, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
